// File: rtl/epwm_pkg.sv
// Shared constants, word map and sequencer state encoding for the ePWM fade controller.
package epwm_pkg;

  localparam logic [1:0] EPWM_W_MODE     = 2'd0;
  localparam logic [1:0] EPWM_W_PRD_CMPA = 2'd1;
  localparam logic [1:0] EPWM_W_CMPBC    = 2'd2;

  localparam logic [7:0] EPWM_MODE_RUN = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_P1,
    ST_WR_P2,
    ST_WR_MODE,
    ST_WAIT,
    ST_CALC,
    ST_WR_C1,
    ST_WR_C2,
    ST_HOLD,
    ST_WR_STOP
  } epwm_state_e;

  function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/epwm_ramp_step.sv
// One ramp step for a single compare channel: move cur toward tgt by at most step.
module epwm_ramp_step (
  input  logic [15:0] cur,
  input  logic [15:0] tgt,
  input  logic [15:0] step,
  output logic [15:0] nxt
);

  logic [16:0] up_diff;
  logic [16:0] dn_diff;
  logic [16:0] step_w;

  always_comb begin
    step_w  = {1'b0, step};
    up_diff = {1'b0, tgt} - {1'b0, cur};
    dn_diff = {1'b0, cur} - {1'b0, tgt};
    nxt     = cur;
    if (cur < tgt) begin
      nxt = cur + ((step_w < up_diff) ? step : up_diff[15:0]);
    end else if (cur > tgt) begin
      nxt = cur - ((step_w < dn_diff) ? step : dn_diff[15:0]);
    end
  end

endmodule

// File: rtl/epwm_fade_ctrl.sv
// Sequencer that programs the 3-channel ePWM and ramps CMPA/B/C toward targets,
// one step every div PWM periods, writing through a valid/ready master port.
module epwm_fade_ctrl
  import epwm_pkg::*;
#(
  parameter int         DIV_W    = 8,
  parameter logic [7:0] MODE_RUN = EPWM_MODE_RUN
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      prd_cfg,
  input  logic [15:0]      tgt_a,
  input  logic [15:0]      tgt_b,
  input  logic [15:0]      tgt_c,
  input  logic [15:0]      step,
  input  logic [DIV_W-1:0] div,
  input  logic             prd_sync,
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic [1:0]       cfg_word,
  output logic [31:0]      cfg_data,
  output logic [15:0]      cur_a,
  output logic [15:0]      cur_b,
  output logic [15:0]      cur_c,
  output logic             busy,
  output logic             done,
  output epwm_state_e      dbg_state
);

  // Write port: a word moves on any cycle with cfg_valid & cfg_ready; while
  // valid is high and ready low, word and data are frozen; only one write is
  // ever outstanding, and valid stays high only when another write follows.

  epwm_state_e      state_q, state_d;
  logic [15:0]      prd_q, prd_d;
  logic [15:0]      tgt_a_q, tgt_a_d, tgt_b_q, tgt_b_d, tgt_c_q, tgt_c_d;
  logic [15:0]      step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [1:0]       cfg_word_q, cfg_word_d;
  logic [31:0]      cfg_data_q, cfg_data_d;
  logic [15:0]      cur_a_q, cur_a_d, cur_b_q, cur_b_d, cur_c_q, cur_c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [15:0] nxt_a, nxt_b, nxt_c;
  logic [15:0] lat_lim;
  logic        xfer;
  logic        do_latch;
  logic        stop_now;
  logic        all_eq;

  epwm_ramp_step u_step_a (.cur(cur_a_q), .tgt(tgt_a_q), .step(step_q), .nxt(nxt_a));
  epwm_ramp_step u_step_b (.cur(cur_b_q), .tgt(tgt_b_q), .step(step_q), .nxt(nxt_b));
  epwm_ramp_step u_step_c (.cur(cur_c_q), .tgt(tgt_c_q), .step(step_q), .nxt(nxt_c));

  always_comb begin
    state_d     = state_q;
    prd_d       = prd_q;
    tgt_a_d     = tgt_a_q;
    tgt_b_d     = tgt_b_q;
    tgt_c_d     = tgt_c_q;
    step_d      = step_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    cfg_valid_d = cfg_valid_q;
    cfg_word_d  = cfg_word_q;
    cfg_data_d  = cfg_data_q;
    cur_a_d     = cur_a_q;
    cur_b_d     = cur_b_q;
    cur_c_d     = cur_c_q;
    done_d      = 1'b0;

    xfer     = cfg_valid_q & cfg_ready;
    stop_now = stop | stop_pend_q;

    // The period may only change when the PWM is idle or parked at target.
    lat_lim  = (state_q == ST_IDLE || state_q == ST_HOLD) ? prd_cfg : prd_q;
    do_latch = start && !stop &&
               (state_q == ST_IDLE || state_q == ST_HOLD || state_q == ST_WAIT ||
                state_q == ST_CALC || state_q == ST_WR_C1 || state_q == ST_WR_C2);
    if (do_latch) begin
      prd_d   = lat_lim;
      tgt_a_d = clamp16(tgt_a, lat_lim);
      tgt_b_d = clamp16(tgt_b, lat_lim);
      tgt_c_d = clamp16(tgt_c, lat_lim);
      step_d  = (step == 16'd0) ? 16'd1 : step;
      div_d   = (div == '0) ? DIV_W'(1) : div;
    end

    case (state_q)
      ST_IDLE: begin
        if (do_latch) begin
          cur_a_d     = 16'd0;
          cur_b_d     = 16'd0;
          cur_c_d     = 16'd0;
          state_d     = ST_WR_P1;
          cfg_valid_d = 1'b1;
          cfg_word_d  = EPWM_W_PRD_CMPA;
          cfg_data_d  = {16'd0, prd_cfg};
        end
      end
      ST_HOLD, ST_WAIT, ST_CALC: begin
        if (stop) begin
          state_d     = ST_WR_STOP;
          cfg_valid_d = 1'b1;
          cfg_word_d  = EPWM_W_MODE;
          cfg_data_d  = 32'd0;
          cur_a_d     = 16'd0;
          cur_b_d     = 16'd0;
          cur_c_d     = 16'd0;
        end else if (state_q == ST_HOLD) begin
          if (do_latch) begin
            state_d     = ST_WR_P1;
            cfg_valid_d = 1'b1;
            cfg_word_d  = EPWM_W_PRD_CMPA;
            cfg_data_d  = {cur_a_q, prd_cfg};
          end
        end else if (state_q == ST_WAIT) begin
          if (prd_sync) begin
            if (cnt_q >= div_q - DIV_W'(1)) begin
              cnt_d   = '0;
              state_d = ST_CALC;
            end else begin
              cnt_d = cnt_q + DIV_W'(1);
            end
          end
        end else begin
          cur_a_d     = nxt_a;
          cur_b_d     = nxt_b;
          cur_c_d     = nxt_c;
          state_d     = ST_WR_C1;
          cfg_valid_d = 1'b1;
          cfg_word_d  = EPWM_W_PRD_CMPA;
          cfg_data_d  = {nxt_a, prd_q};
        end
      end
      ST_WR_STOP: begin
        if (xfer) begin
          cfg_valid_d = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        // Remaining states each hold one write in flight until it is accepted.
        if (!xfer) begin
          if (stop) stop_pend_d = 1'b1;
        end else if (stop_now) begin
          stop_pend_d = 1'b0;
          state_d     = ST_WR_STOP;
          cfg_valid_d = 1'b1;
          cfg_word_d  = EPWM_W_MODE;
          cfg_data_d  = 32'd0;
          cur_a_d     = 16'd0;
          cur_b_d     = 16'd0;
          cur_c_d     = 16'd0;
        end else begin
          case (state_q)
            ST_WR_P1, ST_WR_C1: begin
              state_d    = (state_q == ST_WR_P1) ? ST_WR_P2 : ST_WR_C2;
              cfg_word_d = EPWM_W_CMPBC;
              cfg_data_d = {cur_c_q, cur_b_q};
            end
            ST_WR_P2: begin
              state_d    = ST_WR_MODE;
              cfg_word_d = EPWM_W_MODE;
              cfg_data_d = {24'd0, MODE_RUN};
            end
            ST_WR_MODE: begin
              cfg_valid_d = 1'b0;
              cnt_d       = '0;
              state_d     = ST_WAIT;
            end
            default: begin
              cfg_valid_d = 1'b0;
              if (all_eq) begin
                done_d  = 1'b1;
                state_d = ST_HOLD;
              end else begin
                state_d = ST_WAIT;
              end
            end
          endcase
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_HOLD);
  end

  // Compared against the freshly latched targets so a retarget on the final write is honoured.
  assign all_eq = (cur_a_q == tgt_a_d) && (cur_b_q == tgt_b_d) && (cur_c_q == tgt_c_d);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      prd_q       <= 16'd0;
      tgt_a_q     <= 16'd0;
      tgt_b_q     <= 16'd0;
      tgt_c_q     <= 16'd0;
      step_q      <= 16'd0;
      div_q       <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_word_q  <= 2'd0;
      cfg_data_q  <= 32'd0;
      cur_a_q     <= 16'd0;
      cur_b_q     <= 16'd0;
      cur_c_q     <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prd_q       <= prd_d;
      tgt_a_q     <= tgt_a_d;
      tgt_b_q     <= tgt_b_d;
      tgt_c_q     <= tgt_c_d;
      step_q      <= step_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_word_q  <= cfg_word_d;
      cfg_data_q  <= cfg_data_d;
      cur_a_q     <= cur_a_d;
      cur_b_q     <= cur_b_d;
      cur_c_q     <= cur_c_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_word  = cfg_word_q;
  assign cfg_data  = cfg_data_q;
  assign cur_a     = cur_a_q;
  assign cur_b     = cur_b_q;
  assign cur_c     = cur_c_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_epwm_fade_ctrl.sv
// Scoreboard bench for epwm_fade_ctrl: a ramp model predicts every accepted ePWM write.
module tb_epwm_fade_ctrl;
  import epwm_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start, stop, prd_sync, cfg_ready;
  logic [15:0] prd_cfg, tgt_a, tgt_b, tgt_c, step;
  logic [7:0]  div;
  logic        cfg_valid;
  logic [1:0]  cfg_word;
  logic [31:0] cfg_data;
  logic [15:0] cur_a, cur_b, cur_c;
  logic        busy, done;
  epwm_state_e dbg_state;

  epwm_fade_ctrl #(.DIV_W(8), .MODE_RUN(8'h01)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .stop(stop),
    .prd_cfg(prd_cfg), .tgt_a(tgt_a), .tgt_b(tgt_b), .tgt_c(tgt_c),
    .step(step), .div(div), .prd_sync(prd_sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_word(cfg_word), .cfg_data(cfg_data),
    .cur_a(cur_a), .cur_b(cur_b), .cur_c(cur_c), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 HCLK = ~HCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [1:0]  prev_word;
  logic [31:0] prev_data;

  int m_prd, m_step, m_div;
  int m_tgt[3];
  int m_cur[3];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // monitor: accepted writes, stall stability, done pulses
  always @(negedge HCLK) begin
    if (HRESET) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", 64'(cfg_valid), 64'd1);
        check_eq("stall_word", 64'(cfg_word), 64'(prev_word));
        check_eq("stall_data", 64'(cfg_data), 64'(prev_data));
      end
      if (cfg_valid && cfg_ready) begin
        wr_cnt++;
        if (exp_q.size() == 0) check_eq("wr_unexpected", 64'(exp_q.size()), 64'd1);
        else check_eq("wr", 64'({cfg_word, cfg_data}), 64'(exp_q.pop_front()));
      end
      stall_prev = cfg_valid && !cfg_ready;
      prev_word  = cfg_word;
      prev_data  = cfg_data;
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] p, a, b, c, s, input logic [7:0] d);
    prd_cfg = p; tgt_a = a; tgt_b = b; tgt_c = c; step = s; div = d;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_sync();
    prd_sync = 1'b1;
    tick(1);
    prd_sync = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  // reference model
  task automatic model_start(input int p, a, b, c, s, d, input bit keep_cur);
    m_prd    = p;
    m_tgt[0] = (a > p) ? p : a;
    m_tgt[1] = (b > p) ? p : b;
    m_tgt[2] = (c > p) ? p : c;
    m_step   = (s == 0) ? 1 : s;
    m_div    = (d == 0) ? 1 : d;
    if (!keep_cur) for (int i = 0; i < 3; i++) m_cur[i] = 0;
    exp_q.push_back({2'd1, 16'(m_cur[0]), 16'(m_prd)});
    exp_q.push_back({2'd2, 16'(m_cur[2]), 16'(m_cur[1])});
    exp_q.push_back({2'd0, 32'h0000_0001});
  endtask

  task automatic model_step(output bit at_tgt);
    int dlt;
    at_tgt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dlt = m_tgt[i] - m_cur[i];
      if (dlt > 0) m_cur[i] = m_cur[i] + ((dlt < m_step) ? dlt : m_step);
      else if (dlt < 0) m_cur[i] = m_cur[i] - ((-dlt < m_step) ? -dlt : m_step);
      if (m_cur[i] != m_tgt[i]) at_tgt = 1'b0;
    end
    exp_q.push_back({2'd1, 16'(m_cur[0]), 16'(m_prd)});
    exp_q.push_back({2'd2, 16'(m_cur[2]), 16'(m_cur[1])});
  endtask

  task automatic run_ramp(input int bp_step);
    bit at;
    int n;
    int prev_a;
    n = 0;
    do begin
      prev_a = m_cur[0];
      model_step(at);
      for (int k = 0; k < m_div; k++) begin
        if (k > 0) check_eq("div_hold_a", 64'(cur_a), 64'(prev_a));
        if (n == bp_step && k == m_div - 1) begin
          cfg_ready = 1'b0;
          pulse_sync();
          tick(6);
          check_eq("bp_state", 64'(dbg_state), 64'(ST_WR_C1));
          cfg_ready = 1'b1;
        end else begin
          pulse_sync();
        end
        tick(6);
      end
      check_eq("cur_a", 64'(cur_a), 64'(m_cur[0]));
      check_eq("cur_b", 64'(cur_b), 64'(m_cur[1]));
      check_eq("cur_c", 64'(cur_c), 64'(m_cur[2]));
      n++;
    end while (!at && n < 40);
    check_eq("ramp_bound", 64'(at), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(cfg_valid), 64'd0);
    check_eq({tag, "_word"},  64'(cfg_word), 64'd0);
    check_eq({tag, "_data"},  64'(cfg_data), 64'd0);
    check_eq({tag, "_cur"},   64'({cur_a, cur_b, cur_c}), 64'd0);
    check_eq({tag, "_busy"},  64'(busy), 64'd0);
    check_eq({tag, "_done"},  64'(done), 64'd0);
    check_eq({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // stimulus
  initial begin
    int w0;
    HRESET = 1'b1; start = 1'b0; stop = 1'b0; prd_sync = 1'b0; cfg_ready = 1'b1;
    prd_cfg = '0; tgt_a = '0; tgt_b = '0; tgt_c = '0; step = '0; div = '0;
    for (int i = 0; i < 3; i++) m_cur[i] = 0;
    tick(3);
    check_reset_outputs("reset");
    HRESET = 1'b0;
    tick(2);

    // soft start
    model_start(100, 40, 100, 0, 10, 1, 1'b0);
    pulse_start(16'd100, 16'd40, 16'd100, 16'd0, 16'd10, 8'd1);
    check_eq("start_latency_valid", 64'(cfg_valid), 64'd1);
    check_eq("start_latency_word", 64'(cfg_word), 64'd1);
    check_eq("start_busy", 64'(busy), 64'd1);
    tick(6);
    run_ramp(-1);
    check_eq("soft_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("soft_wr_cnt", 64'(wr_cnt), 64'd23);
    check_eq("soft_hold_state", 64'(dbg_state), 64'(ST_HOLD));
    check_eq("soft_hold_busy", 64'(busy), 64'd0);

    // stop from HOLD, then clamp / odd step / div 2 with backpressure on a step write
    exp_q.push_back({2'd0, 32'd0});
    pulse_stop();
    tick(3);
    check_eq("stop_hold_state", 64'(dbg_state), 64'(ST_IDLE));
    for (int i = 0; i < 3; i++) m_cur[i] = 0;
    model_start(50, 70, 0, 0, 15, 2, 1'b0);
    pulse_start(16'd50, 16'd70, 16'd0, 16'd0, 16'd15, 8'd2);
    tick(6);
    run_ramp(1);
    check_eq("clamp_done_cnt", 64'(done_cnt), 64'd2);
    check_eq("clamp_cur_a", 64'(cur_a), 64'd50);

    // from HOLD: ramp up to 80, then fade down to 20
    model_start(100, 80, 0, 0, 30, 1, 1'b1);
    pulse_start(16'd100, 16'd80, 16'd0, 16'd0, 16'd30, 8'd1);
    tick(6);
    run_ramp(-1);
    model_start(100, 20, 0, 0, 30, 1, 1'b1);
    pulse_start(16'd100, 16'd20, 16'd0, 16'd0, 16'd30, 8'd1);
    tick(6);
    run_ramp(-1);
    check_eq("fade_done_cnt", 64'(done_cnt), 64'd4);
    check_eq("fade_cur_a", 64'(cur_a), 64'd20);

    // stop during WAIT
    begin
      bit at;
      model_start(100, 100, 0, 0, 10, 1, 1'b1);
      pulse_start(16'd100, 16'd100, 16'd0, 16'd0, 16'd10, 8'd1);
      tick(6);
      model_step(at);
      pulse_sync();
      tick(6);
      check_eq("pre_stop_cur_a", 64'(cur_a), 64'd30);
      check_eq("pre_stop_state", 64'(dbg_state), 64'(ST_WAIT));
    end
    exp_q.push_back({2'd0, 32'd0});
    pulse_stop();
    check_eq("stop_cur", 64'({cur_a, cur_b, cur_c}), 64'd0);
    tick(1);
    check_eq("stop_busy", 64'(busy), 64'd0);
    check_eq("stop_state", 64'(dbg_state), 64'(ST_IDLE));
    tick(4);
    check_eq("stop_no_done", 64'(done_cnt), 64'd4);
    check_eq("stop_q_empty", 64'(exp_q.size()), 64'd0);

    // stop while a write is stalled
    cfg_ready = 1'b0;
    exp_q.push_back({2'd1, 16'd0, 16'd60});
    exp_q.push_back({2'd0, 32'd0});
    pulse_start(16'd60, 16'd10, 16'd10, 16'd10, 16'd5, 8'd1);
    tick(2);
    pulse_stop();
    tick(2);
    cfg_ready = 1'b1;
    tick(5);
    check_eq("stall_stop_state", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("stall_stop_q_empty", 64'(exp_q.size()), 64'd0);

    // step 0 / div 0 behave as 1
    for (int i = 0; i < 3; i++) m_cur[i] = 0;
    model_start(20, 3, 0, 0, 0, 0, 1'b0);
    pulse_start(16'd20, 16'd3, 16'd0, 16'd0, 16'd0, 8'd0);
    tick(6);
    run_ramp(-1);
    check_eq("zero_cfg_done_cnt", 64'(done_cnt), 64'd5);
    exp_q.push_back({2'd0, 32'd0});
    pulse_stop();
    tick(3);

    // simultaneous start and stop from IDLE
    w0 = wr_cnt;
    prd_cfg = 16'd10; tgt_a = 16'd5; step = 16'd1; div = 8'd1;
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(4);
    check_eq("startstop_writes", 64'(wr_cnt), 64'(w0));
    check_eq("startstop_state", 64'(dbg_state), 64'(ST_IDLE));

    // HRESET while a write is pending
    w0 = wr_cnt;
    cfg_ready = 1'b0;
    pulse_start(16'd100, 16'd50, 16'd50, 16'd50, 16'd10, 8'd1);
    tick(2);
    check_eq("pre_reset_valid", 64'(cfg_valid), 64'd1);
    HRESET = 1'b1;
    tick(1);
    HRESET = 1'b0;
    check_reset_outputs("midreset");
    cfg_ready = 1'b1;
    tick(4);
    check_eq("midreset_writes", 64'(wr_cnt), 64'(w0));
    check_eq("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
